// File: rtl/hid_frame_tx.sv
// hid_frame_tx: serialises key, mouse and status-poll frames as strobed bytes with fixed inter-byte gaps.
// Status frames and response capture are built only when HID_TX_STATUS_EN is defined.
module hid_frame_tx #(
    parameter int GAP         = 4,
    parameter int KFIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        key_valid,
    input  logic [7:0]  key_code,
    output logic        key_ready,
    input  logic        mouse_valid,
    input  logic [1:0]  mouse_btns,
    input  logic [7:0]  mouse_dx,
    input  logic [7:0]  mouse_dy,
    input  logic        status_req,
    output logic [15:0] status_rsp,
    output logic        status_done,
    output logic        tx_strobe,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    input  logic [7:0]  rx_data
);
    localparam int AW = KFIFO_DEPTH > 1 ? $clog2(KFIFO_DEPTH) : 1;
    localparam int GW = $clog2(GAP + 1);
    typedef enum logic [1:0] {S_IDLE, S_ARB, S_BYTE, S_GAP} state_t;
    state_t state, state_n;
    logic [7:0] fifo [KFIFO_DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0] cnt;
    logic push, pop, sel_key, sel_mouse, sel_stat, stat_pend, m_pend, gap_last, is_stat;
    logic [1:0] m_btns, idx, last;
    logic [7:0] m_dx, m_dy;
    logic [7:0] fb [4];
    logic [GW-1:0] gcnt;

    function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = {a[7], a} + {b[7], b};
        return (s[8] != s[7]) ? (s[8] ? 8'h80 : 8'h7F) : s[7:0];
    endfunction

    // a pop in ARB frees a slot in the same cycle, so a full FIFO still accepts then
    assign key_ready = cnt != (AW + 1)'(KFIFO_DEPTH) || pop;
    assign push      = key_valid && key_ready;
    assign pop       = sel_key;
    assign gap_last  = gcnt == GW'(GAP - 1);

    always_ff @(posedge clk)
        state <= reset ? S_IDLE : state_n;

    always_comb begin
        state_n   = state;
        sel_key   = 1'b0;
        sel_mouse = 1'b0;
        sel_stat  = 1'b0;
        tx_strobe = 1'b0;
        tx_start  = 1'b0;
        tx_data   = 8'h00;
        case (state)
            S_IDLE: state_n = (cnt != '0 || m_pend || stat_pend) ? S_ARB : S_IDLE;
            S_ARB: begin
                sel_key   = cnt != '0;
                sel_mouse = !sel_key && m_pend;
                sel_stat  = !sel_key && !m_pend && stat_pend;
                state_n   = (sel_key || sel_mouse || sel_stat) ? S_BYTE : S_IDLE;
            end
            S_BYTE: begin
                tx_strobe = 1'b1;
                tx_start  = idx == 2'd0;
                tx_data   = fb[idx];
                state_n   = S_GAP;
            end
            default: state_n = gap_last ? (idx == last ? S_ARB : S_BYTE) : S_GAP;
        endcase
    end

    always_ff @(posedge clk)
        if (push) fifo[wp] <= key_code;

    always_ff @(posedge clk) begin
        if (reset) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            wp  <= push ? wp + 1'b1 : wp;
            rp  <= pop ? rp + 1'b1 : rp;
            cnt <= cnt + (AW + 1)'(push) - (AW + 1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx     <= '0;
            last    <= '0;
            gcnt    <= '0;
            is_stat <= 1'b0;
            fb      <= '{default: '0};
        end else if (state == S_ARB) begin
            idx     <= '0;
            gcnt    <= '0;
            is_stat <= sel_stat;
            last    <= sel_key ? 2'd1 : sel_mouse ? 2'd3 : 2'd2;
            fb[0]   <= sel_key ? 8'h01 : sel_mouse ? 8'h02 : 8'h00;
            fb[1]   <= sel_key ? fifo[rp] : sel_mouse ? {6'b0, m_btns} : 8'h00;
            fb[2]   <= sel_mouse ? m_dx : 8'h00;
            fb[3]   <= sel_mouse ? m_dy : 8'h00;
        end else if (state == S_GAP) begin
            gcnt <= gap_last ? '0 : gcnt + 1'b1;
            idx  <= gap_last ? idx + 2'd1 : idx;
        end
    end

    // latching a mouse frame restarts the accumulators, seeded by any same-cycle event
    always_ff @(posedge clk) begin
        if (reset) begin
            m_pend <= 1'b0;
            m_btns <= '0;
            m_dx   <= '0;
            m_dy   <= '0;
        end else if (sel_mouse) begin
            m_pend <= mouse_valid;
            m_btns <= mouse_valid ? mouse_btns : m_btns;
            m_dx   <= mouse_valid ? mouse_dx : 8'h00;
            m_dy   <= mouse_valid ? mouse_dy : 8'h00;
        end else if (mouse_valid) begin
            m_pend <= 1'b1;
            m_btns <= mouse_btns;
            m_dx   <= sat_add(m_dx, mouse_dx);
            m_dy   <= sat_add(m_dy, mouse_dy);
        end
    end

`ifdef HID_TX_STATUS_EN
    logic samp;
    assign samp = state == S_GAP && gap_last && is_stat && idx != 2'd0;

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_pend   <= 1'b0;
            status_rsp  <= '0;
            status_done <= 1'b0;
        end else begin
            stat_pend   <= status_req || (stat_pend && !sel_stat);
            status_done <= samp && idx == 2'd2;
            if (samp && idx == 2'd1) status_rsp[15:8] <= rx_data;
            if (samp && idx == 2'd2) status_rsp[7:0] <= rx_data;
        end
    end
`else
    logic unused_status;
    assign unused_status = status_req ^ (^rx_data) ^ is_stat;
    assign stat_pend     = 1'b0;
    assign status_rsp    = '0;
    assign status_done   = 1'b0;
`endif
endmodule

// File: tb/tb_hid_frame_tx.sv
// tb_hid_frame_tx: scoreboard bench; expected bytes are queued as stimulus is applied and popped on each strobe.
module tb_hid_frame_tx;
    localparam int GAP = 4;
    logic        clk = 1'b0;
    logic        reset, key_valid, key_ready, mouse_valid, status_req, status_done;
    logic        tx_strobe, tx_start;
    logic [7:0]  key_code, mouse_dx, mouse_dy, tx_data;
    logic [7:0]  rx_data = 8'hEE;
    logic [1:0]  mouse_btns;
    logic [15:0] status_rsp, exp_rsp = 16'h0000;
    logic [8:0]  sb [$];
    int n_cmp = 0, n_err = 0, cyc = 0, last_strobe = -1000, done_cnt = 0;
    int rx_cnt = 0, bidx = 0;
    logic [7:0] rx_val = 8'h00, f0 = 8'hFF;

    hid_frame_tx #(.GAP(GAP), .KFIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code),
        .key_ready(key_ready), .mouse_valid(mouse_valid), .mouse_btns(mouse_btns),
        .mouse_dx(mouse_dx), .mouse_dy(mouse_dy), .status_req(status_req),
        .status_rsp(status_rsp), .status_done(status_done), .tx_strobe(tx_strobe),
        .tx_start(tx_start), .tx_data(tx_data), .rx_data(rx_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void exp_key(input logic [7:0] c);
        sb.push_back({1'b1, 8'h01});
        sb.push_back({1'b0, c});
    endfunction

    function automatic void exp_mouse(input logic [1:0] b, input logic [7:0] x, input logic [7:0] y);
        sb.push_back({1'b1, 8'h02});
        sb.push_back({1'b0, 6'b0, b});
        sb.push_back({1'b0, x});
        sb.push_back({1'b0, y});
    endfunction

    // far end answers only in the final gap cycle after status bytes 2 and 3
    always @(negedge clk) begin
        rx_data = (rx_cnt == 1) ? rx_val : 8'hEE;
        if (rx_cnt != 0) rx_cnt--;
        if (tx_strobe) begin
            if (tx_start) begin
                bidx = 0;
                f0 = tx_data;
            end else bidx++;
            if (f0 == 8'h00 && (bidx == 1 || bidx == 2)) begin
                rx_val = (bidx == 1) ? 8'h5C : 8'h42;
                rx_cnt = GAP;
            end
            if (sb.size() == 0) check("extra strobe", tx_strobe, 0);
            else check("tx byte", {tx_start, tx_data}, sb.pop_front());
            if (!tx_start) check("byte spacing", cyc - last_strobe, GAP + 1);
            else check("frame spacing short", (cyc - last_strobe) < GAP + 2, 0);
            last_strobe = cyc;
        end
        if (status_done) begin
            done_cnt++;
            check("rsp at done", status_rsp, exp_rsp);
        end
    end

    task automatic push_key(input logic [7:0] c);
        int n;
        n = 0;
        key_valid = 1'b1;
        key_code = c;
        exp_key(c);
        while (!key_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n == 200) check("key accept timeout", key_ready, 1);
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic mouse(input logic [1:0] b, input logic [7:0] x, input logic [7:0] y);
        mouse_valid = 1'b1;
        mouse_btns = b;
        mouse_dx = x;
        mouse_dy = y;
        @(negedge clk);
        mouse_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) check("drain timeout", sb.size(), 0);
        repeat (GAP + 10) @(negedge clk);
    endtask

    task automatic wait_q(input int sz);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (sb.size() != sz && n < 500);
        if (sb.size() != sz) check("wait queue timeout", sb.size(), sz);
    endtask

    initial begin
        reset = 1'b1; key_valid = 1'b0; key_code = '0; mouse_valid = 1'b0;
        mouse_btns = '0; mouse_dx = '0; mouse_dy = '0; status_req = 1'b0;
        repeat (3) @(negedge clk);
        check("reset strobe", tx_strobe, 0);
        check("reset start", tx_start, 0);
        check("reset data", tx_data, 8'h00);
        check("reset rsp", status_rsp, 16'h0000);
        check("reset done", status_done, 0);
        reset = 1'b0;
        @(negedge clk);
        check("ready after reset", key_ready, 1);

        push_key(8'h93);
        check("ready single key", key_ready, 1);
        drain();

        push_key(8'h11);
        repeat (4) @(negedge clk);
        mouse(2'd1, 8'd100, 8'hFD);
        mouse(2'd2, 8'd100, 8'hFE);
        exp_mouse(2'd2, 8'h7F, 8'hFB);
        drain();

        mouse(2'd0, 8'h9C, 8'h80);
        mouse(2'd3, 8'h9C, 8'hFF);
        exp_mouse(2'd3, 8'h80, 8'h80);
        drain();

        mouse(2'd3, 8'h00, 8'h00);
        exp_mouse(2'd3, 8'h00, 8'h00);
        drain();

        mouse(2'd1, 8'd1, 8'd0);
        mouse(2'd1, 8'd2, 8'd0);
        mouse(2'd2, 8'd4, 8'd1);
        exp_mouse(2'd1, 8'd3, 8'd0);
        exp_mouse(2'd2, 8'd4, 8'd1);
        drain();

        mouse(2'd1, 8'd5, 8'd5);
        exp_mouse(2'd1, 8'd5, 8'd5);
        wait_q(3);
        for (int i = 0; i < 5; i++) begin
            push_key(8'h20 + 8'(i));
            if (i == 3) check("ready low when full", key_ready, 0);
        end
        drain();

        key_valid = 1'b1; key_code = 8'h2A;
        mouse_valid = 1'b1; mouse_btns = 2'd1; mouse_dx = 8'd7; mouse_dy = 8'hFF;
        status_req = 1'b1;
        @(negedge clk);
        key_valid = 1'b0; mouse_valid = 1'b0; status_req = 1'b0;
        exp_key(8'h2A);
        exp_mouse(2'd1, 8'd7, 8'hFF);
`ifdef HID_TX_STATUS_EN
        sb.push_back({1'b1, 8'h00});
        sb.push_back({1'b0, 8'h00});
        sb.push_back({1'b0, 8'h00});
        exp_rsp = 16'h5C42;
`endif
        repeat (6) @(negedge clk);
        status_req = 1'b1;
        @(negedge clk);
        status_req = 1'b0;
        drain();
        check("status rsp", status_rsp, exp_rsp);
`ifdef HID_TX_STATUS_EN
        check("status done pulses", done_cnt, 1);
`else
        check("status done pulses", done_cnt, 0);
`endif

        mouse(2'd2, 8'd9, 8'd9);
        exp_mouse(2'd2, 8'd9, 8'd9);
        wait_q(2);
        reset = 1'b1;
        sb.delete();
        @(negedge clk);
        check("abort strobe", tx_strobe, 0);
        check("abort start", tx_start, 0);
        check("abort data", tx_data, 8'h00);
        check("abort rsp", status_rsp, 16'h0000);
        check("abort done", status_done, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check("ready after abort", key_ready, 1);
        push_key(8'h55);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule

// File: doc/hid_frame_tx.md
HID_FRAME_TX -- requirements
Module: hid_frame_tx

Interface
REQ-001 The block SHALL have parameter GAP, default 4, giving the number of idle cycles between consecutive byte strobes (minimum 1).
REQ-002 The block SHALL have parameter KFIFO_DEPTH, default 4, giving the key event FIFO depth (power of two).
REQ-003 The block SHALL have ports, in this order:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- key_valid  in  1  key event offered
- key_code  in  8  {state, row[2:0], col[3:0]}; bit7=1 released, 0 pressed
- key_ready  out  1  FIFO not full
- mouse_valid  in  1  mouse event, always accepted
- mouse_btns  in  2  button state
- mouse_dx  in  8  signed X delta
- mouse_dy  in  8  signed Y delta
- status_req  in  1  one-cycle status poll request
- status_rsp  out  16  last status response {byte1, byte2}
- status_done  out  1  one-cycle pulse when status_rsp updates
- tx_strobe  out  1  one-cycle byte strobe
- tx_start  out  1  marks the frame's first byte; valid with tx_strobe
- tx_data  out  8  byte value; valid with tx_strobe
- rx_data  in  8  byte returned by the far end

Function
REQ-004 Frame formats SHALL be:
- status: 0x00, 0x00, 0x00
- key: 0x01, key_code
- mouse: 0x02, {6'b0, btns}, dx, dy
REQ-005 tx_start SHALL be high only with the first byte's strobe.
REQ-006 The FSM SHALL have states IDLE, ARB, BYTE, GAP: IDLE->ARB when any source is pending; ARB selects the frame and latches its bytes; BYTE asserts tx_strobe for one cycle; GAP counts GAP cycles, then goes to BYTE if bytes remain, else to ARB.
REQ-007 Arbitration priority SHALL be key > mouse > status; the selected frame always completes before the next is chosen.
REQ-008 Key events SHALL be accepted when key_valid && key_ready, stored in FIFO order, and popped in ARB.
REQ-009 key_ready SHALL fall when the FIFO holds KFIFO_DEPTH entries; a pop and a push in the same cycle SHALL both succeed when full.
REQ-010 Mouse events SHALL accumulate into pending dx/dy with signed saturation to -128..+127; buttons take the latest value; the pending flag is set.
REQ-011 In the cycle ARB latches a mouse frame, accumulators SHALL clear; a simultaneous mouse_valid SHALL load its values as the new pending event.
REQ-012 A mouse event with dx=dy=0 SHALL still set pending, so button changes are transmitted.
REQ-013 status_req SHALL set a pending flag; repeated requests while pending SHALL merge into one.
REQ-014 rx_data SHALL be sampled in the last GAP cycle after the 2nd and 3rd status-frame strobes into status_rsp[15:8] and [7:0]; status_done pulses one cycle after the second sample.
REQ-015 Byte spacing SHALL be exactly GAP+1 cycles strobe-to-strobe within a frame; between frames, spacing SHALL be GAP+2 cycles, due to ARB.

Reset
REQ-016 Reset SHALL:
- force the FSM to IDLE;
- empty the FIFO;
- clear mouse accumulators and pending flags;
- set tx_strobe=0, tx_start=0, tx_data=0x00, status_rsp=0x0000, status_done=0.
REQ-017 key_ready SHALL be 1 from the first cycle after reset.
REQ-018 Reset mid-frame SHALL abort the frame without emitting further strobes.

Configuration
REQ-019 With HID_TX_STATUS_EN defined, status frames and REQ-013/014 SHALL be implemented.
REQ-020 Without HID_TX_STATUS_EN, status_req SHALL be ignored, status_rsp SHALL hold 0x0000, and status_done SHALL hold 0.

Verification
REQ-021 Key: key_code=0x93 after reset, GAP=4 -> strobes 0x01 (start=1), then 0x93 5 cycles later; key_ready stays 1.
REQ-022 FIFO full: push 5 keys back-to-back while a mouse frame is in flight -> key_ready low after the 4th; the 5th is held; all 5 keys transmitted in order.
REQ-023 Saturation: mouse dx=+100 then +100 while busy -> mouse frame 0x02, btns, 0x7F, dy.
REQ-024 Simultaneous: key, mouse and status_req in the same cycle -> frames sent in order key, mouse, status with no byte gaps violated.
REQ-025 Status (macro on): rx_data=0x5C and 0x42 during the sample windows -> status_rsp=0x5C42, one status_done pulse; macro off -> no frame, status_rsp=0x0000.
REQ-026 Reset asserted during mouse byte 2 -> no further strobes; outputs at reset values; next key frame is transmitted normally.
